cpc_ram_bank_ctrl: RTL and testbench

//  CPLD core for the CPC RAM expansion boards; generalises the 512K banker to 512K..4M.

---
 rtl/cpc_ram_pkg.sv | 27 ++
 rtl/cpc_ram_bank_ctrl_if.sv | 35 +++
 rtl/cpc_ram_map.sv | 48 ++++
 rtl/cpc_ram_bank_ctrl.sv | 134 +++++++++++++
 tb/tb_cpc_ram_bank_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpc_ram_pkg.sv
// Shared constants for the CPC RAM expansion banker: RAM config encodings,
// gate-array port match values and the capture FSM state type.
package cpc_ram_pkg;

  // RAM configuration codes as written to the gate array in D[2:0].
  localparam logic [2:0] CFG_NONE   = 3'd0;  // no expansion mapping
  localparam logic [2:0] CFG_C3     = 3'd1;  // &C000 -> block 3
  localparam logic [2:0] CFG_FLAT   = 3'd2;  // all regions -> block r
  localparam logic [2:0] CFG_C3_ALT = 3'd3;  // &C000 -> block 3 (host does &4000 part)
  localparam logic [2:0] CFG_P4_7   = 3'd4;  // 4..7: &4000 -> block cfg-4

  // Gate-array write is recognised by A[15:14]=01 on the port and D[7:6]=11.
  localparam logic [1:0] PORT_A_HI  = 2'b01;
  localparam logic [1:0] GA_RAM_SEL = 2'b11;

  // Region index of the &4000 and &C000 windows.
  localparam logic [1:0] REGION_4000 = 2'd1;
  localparam logic [1:0] REGION_C000 = 2'd3;

  // Capture FSM states, exported on the debug port of the top.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_WAIT = 2'd2
  } cap_state_e;

endpackage

// File: rtl/cpc_ram_bank_ctrl_if.sv
// Z80 bus snoop and external SRAM control bundle for the RAM banker.
//
// Bus semantics: there is no valid/ready pair on this bundle. The Z80 side
// (master) owns A/D and the active-low strobes; a transfer exists only while
// its strobes are asserted, and the banker (slave) never stalls it. The SRAM
// controls driven by the slave are pure combinational functions of the
// current strobes, address and the registered bank/config state.
interface cpc_ram_bank_ctrl_if #(
  parameter int EXT_BITS = 0
);
  localparam int HIADR_W = 5 + EXT_BITS;

  logic [15:0]        A;
  logic [7:0]         D;
  logic               MREQ_B;
  logic               IOREQ_B;
  logic               WR_B;
  logic               M1_B;
  logic               RFSH_B;
  logic [HIADR_W-1:0] HIADR;
  logic               RAMCS_B;
  logic               RAMWE_B;
  logic               RAMDIS;

  modport master (
    output A, D, MREQ_B, IOREQ_B, WR_B, M1_B, RFSH_B,
    input  HIADR, RAMCS_B, RAMWE_B, RAMDIS
  );

  modport slave (
    input  A, D, MREQ_B, IOREQ_B, WR_B, M1_B, RFSH_B,
    output HIADR, RAMCS_B, RAMWE_B, RAMDIS
  );

endinterface

// File: rtl/cpc_ram_map.sv
// Pure combinational region/config/bank to SRAM block mapper.
// hit says the region is remapped by the current config; hiadr is
// {bank, blk} where blk is the remapped block on a hit, else the region.
module cpc_ram_map
  import cpc_ram_pkg::*;
#(
  parameter int EXT_BITS = 0
) (
  input  logic [1:0]            region,
  input  logic [2:0]            cfg,
  input  logic [2+EXT_BITS:0]   bank,
  output logic                  hit,
  output logic [4+EXT_BITS:0]   hiadr
);

  logic [1:0] blk;

  // Decode which region the config remaps and to which block.
  always_comb begin
    hit = 1'b0;
    blk = region;
    case (cfg)
      CFG_NONE: begin
        hit = 1'b0;
      end
      CFG_C3, CFG_C3_ALT: begin
        if (region == REGION_C000) begin
          hit = 1'b1;
          blk = 2'd3;
        end
      end
      CFG_FLAT: begin
        hit = 1'b1;
        blk = region;
      end
      default: begin
        // Configs 4..7 page block (cfg-4) into &4000.
        if (region == REGION_4000) begin
          hit = 1'b1;
          blk = cfg[1:0];
        end
      end
    endcase
  end

  assign hiadr = {bank, blk};

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion banker core. Snoops qualified gate-array I/O writes,
// holds the bank/config registers and maps MREQ accesses to external SRAM.
module cpc_ram_bank_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int EXT_BITS = 0,
  parameter int QUAL_CYC = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  cpc_ram_bank_ctrl_if.slave   bus,
  input  logic                 dip_en,
  output logic [2:0]           cfg_q,
  output logic [2+EXT_BITS:0]  bank_q,
  output cap_state_e           fsm_state
);

  localparam int BANK_W  = 3 + EXT_BITS;
  localparam int HIADR_W = 5 + EXT_BITS;
  // Value the sample counter holds when the current sample is the last one needed.
  localparam logic [1:0] QUAL_LAST = 2'(QUAL_CYC - 1);

  cap_state_e          state_q, state_d;
  logic [1:0]          qcnt_q, qcnt_d;
  logic                iowr;
  logic                do_cap;
  logic [BANK_W-1:0]   bank_load;
  logic [1:0]          region;
  logic                map_hit;
  logic [HIADR_W-1:0]  map_hiadr;
  logic                hit;
  logic                mem_act;
  logic                unused_addr;

  // Gate-array port write; interrupt acknowledge (IORQ with M1) is excluded.
  assign iowr = ~bus.IOREQ_B & ~bus.WR_B & bus.M1_B & (bus.A[15:14] == PORT_A_HI);

  // Extended bank bits come from the inverted port address A[10:8].
  if (EXT_BITS > 0) begin : g_ext
    assign bank_load = {~bus.A[8 +: EXT_BITS], bus.D[5:3]};
  end else begin : g_noext
    assign bank_load = bus.D[5:3];
  end

  // Capture FSM state and qualification counter.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state_q <= ST_IDLE;
      qcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
    end
  end

  // Next state: qualify the strobe for QUAL_CYC samples, capture once, then wait for release.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    do_cap  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iowr) begin
          if (QUAL_CYC <= 1) begin
            do_cap  = 1'b1;
            state_d = ST_WAIT;
            qcnt_d  = 2'd0;
          end else begin
            state_d = ST_QUAL;
            qcnt_d  = 2'd1;
          end
        end
      end
      ST_QUAL: begin
        if (!iowr) begin
          state_d = ST_IDLE;
          qcnt_d  = 2'd0;
        end else if (qcnt_q == QUAL_LAST) begin
          do_cap  = 1'b1;
          state_d = ST_WAIT;
          qcnt_d  = 2'd0;
        end else begin
          qcnt_d  = qcnt_q + 2'd1;
        end
      end
      ST_WAIT: begin
        if (!iowr) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        qcnt_d  = 2'd0;
      end
    endcase
  end

  // Bank/config registers; only a RAM-select gate-array write updates them, reset wins.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      cfg_q  <= 3'd0;
      bank_q <= '0;
    end else if (do_cap && (bus.D[7:6] == GA_RAM_SEL)) begin
      cfg_q  <= bus.D[2:0];
      bank_q <= bank_load;
    end
  end

  assign fsm_state = state_q;

  assign region = bus.A[15:14];

  cpc_ram_map #(
    .EXT_BITS (EXT_BITS)
  ) u_map (
    .region (region),
    .cfg    (cfg_q),
    .bank   (bank_q),
    .hit    (map_hit),
    .hiadr  (map_hiadr)
  );

  // SRAM controls: refresh cycles and a disabled expansion never select the SRAM.
  assign hit         = dip_en & map_hit;
  assign mem_act     = hit & ~bus.MREQ_B & bus.RFSH_B;
  assign bus.HIADR   = hit ? map_hiadr : {bank_q, region};
  assign bus.RAMCS_B = ~mem_act;
  assign bus.RAMWE_B = ~(mem_act & ~bus.WR_B);
  assign bus.RAMDIS  = mem_act;

  // Low address lines go straight to the SRAM and are not decoded here.
  assign unused_addr = ^bus.A[13:0];

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Directed bench for the CPC RAM banker: one 512K (EXT_BITS=0) and one
// 2M (EXT_BITS=2) instance driven by the same Z80 bus stimulus.
module tb_cpc_ram_bank_ctrl;
  import cpc_ram_pkg::*;

  logic        clk;
  logic        rst_b;
  logic [15:0] a;
  logic [7:0]  d;
  logic        mreq_b, ioreq_b, wr_b, m1_b, rfsh_b;
  logic        dip_en;

  logic [2:0]  cfg0, cfg2;
  logic [2:0]  bank0;
  logic [4:0]  bank2;
  cap_state_e  fsm0, fsm2;

  logic [15:0] exp_q[$];
  int          vectors;
  int          miscompares;

  cpc_ram_bank_ctrl_if #(.EXT_BITS(0)) bus0 ();
  cpc_ram_bank_ctrl_if #(.EXT_BITS(2)) bus2 ();

  assign bus0.A = a;       assign bus2.A = a;
  assign bus0.D = d;       assign bus2.D = d;
  assign bus0.MREQ_B = mreq_b;   assign bus2.MREQ_B = mreq_b;
  assign bus0.IOREQ_B = ioreq_b; assign bus2.IOREQ_B = ioreq_b;
  assign bus0.WR_B = wr_b;       assign bus2.WR_B = wr_b;
  assign bus0.M1_B = m1_b;       assign bus2.M1_B = m1_b;
  assign bus0.RFSH_B = rfsh_b;   assign bus2.RFSH_B = rfsh_b;

  cpc_ram_bank_ctrl #(.EXT_BITS(0), .QUAL_CYC(2)) u_dut0 (
    .CLK(clk), .RESET_B(rst_b), .bus(bus0), .dip_en(dip_en),
    .cfg_q(cfg0), .bank_q(bank0), .fsm_state(fsm0)
  );

  cpc_ram_bank_ctrl #(.EXT_BITS(2), .QUAL_CYC(2)) u_dut2 (
    .CLK(clk), .RESET_B(rst_b), .bus(bus2), .dip_en(dip_en),
    .cfg_q(cfg2), .bank_q(bank2), .fsm_state(fsm2)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Driver tasks
  task automatic bus_idle();
    mreq_b = 1'b1; ioreq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1; rfsh_b = 1'b1;
  endtask

  // I/O write held for 'cycles' rising edges, then released with idle time after.
  task automatic io_write(input logic [15:0] addr, input logic [7:0] data,
                          input int cycles, input logic m1);
    @(posedge clk); #1;
    a = addr; d = data; ioreq_b = 1'b0; wr_b = 1'b0; m1_b = m1; mreq_b = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mem_drive(input logic [15:0] addr, input logic wr, input logic rfsh);
    a = addr; d = 8'h00; ioreq_b = 1'b1; m1_b = 1'b1;
    mreq_b = 1'b0; wr_b = ~wr; rfsh_b = ~rfsh;
  endtask

  task automatic check_sram(input string tag, input logic cs, input logic we,
                            input logic dis, input logic [4:0] hi0, input logic [6:0] hi2);
    push({15'd0, cs}); push({15'd0, we}); push({15'd0, dis}); push({11'd0, hi0});
    push({15'd0, cs}); push({9'd0, hi2});
    @(negedge clk);
    pop_cmp({tag, "_cs0"},  {15'd0, bus0.RAMCS_B});
    pop_cmp({tag, "_we0"},  {15'd0, bus0.RAMWE_B});
    pop_cmp({tag, "_dis0"}, {15'd0, bus0.RAMDIS});
    pop_cmp({tag, "_hi0"},  {11'd0, bus0.HIADR});
    pop_cmp({tag, "_cs2"},  {15'd0, bus2.RAMCS_B});
    pop_cmp({tag, "_hi2"},  {9'd0, bus2.HIADR});
  endtask

  task automatic check_regs(input string tag, input logic [2:0] cfg,
                            input logic [2:0] b0, input logic [4:0] b2);
    push({13'd0, cfg}); push({13'd0, b0}); push({13'd0, cfg}); push({11'd0, b2});
    @(negedge clk);
    pop_cmp({tag, "_cfg0"},  {13'd0, cfg0});
    pop_cmp({tag, "_bank0"}, {13'd0, bank0});
    pop_cmp({tag, "_cfg2"},  {13'd0, cfg2});
    pop_cmp({tag, "_bank2"}, {11'd0, bank2});
  endtask

  task automatic check_state(input string tag, input cap_state_e st);
    push({14'd0, st}); push({14'd0, st});
    @(negedge clk);
    pop_cmp({tag, "_st0"}, {14'd0, fsm0});
    pop_cmp({tag, "_st2"}, {14'd0, fsm2});
  endtask

  // Directed sequence
  initial begin
    vectors = 0; miscompares = 0;
    a = 16'h0000; d = 8'h00; dip_en = 1'b1; rst_b = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;

    // Reset state
    check_regs("rst", 3'd0, 3'd0, 5'd0);
    check_state("rst", ST_IDLE);
    check_sram("rst_idle", 1'b1, 1'b1, 1'b0, 5'b00000, 7'b0000000);
    mem_drive(16'hC000, 1'b0, 1'b0);
    check_sram("rst_c000", 1'b1, 1'b1, 1'b0, 5'b00011, 7'b0000011);
    bus_idle();

    // 1: config 1 maps &C000 to block 3
    io_write(16'h7FFF, 8'hC1, 2, 1'b1);
    check_regs("t1", 3'd1, 3'd0, 5'd0);
    mem_drive(16'hC123, 1'b0, 1'b0);
    check_sram("t1_rd", 1'b0, 1'b1, 1'b1, 5'b00011, 7'b0000011);
    mem_drive(16'hC123, 1'b1, 1'b0);
    check_sram("t1_wr", 1'b0, 1'b0, 1'b1, 5'b00011, 7'b0000011);
    mem_drive(16'h4000, 1'b0, 1'b0);
    check_sram("t1_4000", 1'b1, 1'b1, 1'b0, 5'b00001, 7'b0000001);
    bus_idle();

    // 2: config 6, bank 2 pages block 2 into &4000
    io_write(16'h7FFF, 8'hD6, 2, 1'b1);
    check_regs("t2", 3'd6, 3'd2, 5'd2);
    mem_drive(16'h4000, 1'b0, 1'b0);
    check_sram("t2_4000", 1'b0, 1'b1, 1'b1, 5'b01010, 7'b0001010);
    mem_drive(16'h8000, 1'b0, 1'b0);
    check_sram("t2_8000", 1'b1, 1'b1, 1'b0, 5'b01010, 7'b0001010);
    bus_idle();

    // 3: extended bank bits from ~A[9:8]
    io_write(16'h7DFF, 8'hC2, 2, 1'b1);
    check_regs("t3", 3'd2, 3'd0, 5'b10000);
    mem_drive(16'h0010, 1'b1, 1'b0);
    check_sram("t3_wr", 1'b0, 1'b0, 1'b1, 5'b00000, 7'b1000000);
    mem_drive(16'h8000, 1'b0, 1'b0);
    check_sram("t3_8000", 1'b0, 1'b1, 1'b1, 5'b00010, 7'b1000010);
    bus_idle();

    // 4: writes that must not capture
    io_write(16'h7FFF, 8'h8C, 2, 1'b1);
    check_regs("t4_d76", 3'd2, 3'd0, 5'b10000);
    io_write(16'h7FFF, 8'hC5, 1, 1'b1);
    check_regs("t4_glitch", 3'd2, 3'd0, 5'b10000);
    io_write(16'h7FFF, 8'hC7, 3, 1'b0);
    check_regs("t4_intack", 3'd2, 3'd0, 5'b10000);
    io_write(16'hBFFF, 8'hC7, 3, 1'b1);
    check_regs("t4_port", 3'd2, 3'd0, 5'b10000);

    // 5: refresh never selects the SRAM; dip_en only gates hits
    io_write(16'h7FFF, 8'hC1, 2, 1'b1);
    check_regs("t5", 3'd1, 3'd0, 5'd0);
    mem_drive(16'hC000, 1'b0, 1'b1);
    check_sram("t5_rfsh", 1'b1, 1'b1, 1'b0, 5'b00011, 7'b0000011);
    mem_drive(16'hC000, 1'b0, 1'b0);
    check_sram("t5_norm", 1'b0, 1'b1, 1'b1, 5'b00011, 7'b0000011);
    dip_en = 1'b0;
    check_sram("t5_dipoff", 1'b1, 1'b1, 1'b0, 5'b00011, 7'b0000011);
    check_regs("t5_dipoff", 3'd1, 3'd0, 5'd0);
    bus_idle();
    io_write(16'h7FFF, 8'hD2, 2, 1'b1);
    check_regs("t5_track", 3'd2, 3'd2, 5'd2);
    mem_drive(16'h0000, 1'b0, 1'b0);
    check_sram("t5_nohit", 1'b1, 1'b1, 1'b0, 5'b01000, 7'b0001000);
    dip_en = 1'b1;
    check_sram("t5_dipon", 1'b0, 1'b1, 1'b1, 5'b01000, 7'b0001000);
    bus_idle();

    // 6: reset during WAIT clears registers, no capture after release
    @(posedge clk); #1;
    a = 16'h7FFF; d = 8'hFF; ioreq_b = 1'b0; wr_b = 1'b0; m1_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_state("t6_wait", ST_WAIT);
    check_regs("t6_cap", 3'd7, 3'd7, 5'd7);
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("t6_rst", 3'd0, 3'd0, 5'd0);
    check_state("t6_rst", ST_IDLE);
    rst_b = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    check_regs("t6_after", 3'd0, 3'd0, 5'd0);
    check_state("t6_after", ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
